// File: rtl/cfsr4_checker.sv
// ============================================================================
// cfsr4_checker
//
// Serial-stream checker for a 4-bit CFSR transmitter.
//
// The transmitter emits bit 0 of its state every step and steps with:
//   fb   = (~S3 & ~S2 & ~S1) ^ S0
//   next = {fb, S3 ^ fb, S2, S1}
// This is a 16-state cycle whose stream from seed 1111 is
// 1110 0010 0011 0101, repeating.
//
// The checker runs a local copy of that generator. It learns the generator
// phase from four received bits (SEARCH), confirms it over LOCK_CNT further
// bits (VERIFY), then counts mismatches (LOCKED). LOSS_THRESH consecutive
// mismatches in LOCKED drop it back to SEARCH.
//
// Parameters
//   LOCK_CNT     consecutive matches needed in VERIFY before lock
//   LOSS_THRESH  consecutive mismatches in LOCKED that cause loss of lock
//   CNT_W        width of the saturating error counter
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   asynchronous reset, active low
//   din        in   serial bit from the transmitter
//   din_valid  in   din is taken only on edges where this is 1
//   clr_cnt    in   synchronous clear of err_cnt (wins over an increment)
//   locked     out  registered, 1 while in LOCKED
//   err        out  registered one-cycle pulse per counted mismatch
//   err_cnt    out  saturating count of mismatches seen in LOCKED
//   state      out  FSM state: SEARCH=00, VERIFY=01, LOCKED=10
// ============================================================================
module cfsr4_checker #(
  parameter int LOCK_CNT    = 8,
  parameter int LOSS_THRESH = 3,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             din_valid,
  input  logic             clr_cnt,
  output logic             locked,
  output logic             err,
  output logic [CNT_W-1:0] err_cnt,
  output logic [1:0]       state
);

  // Run counters only ever hold 0 .. (limit-1); the limit-th event is
  // detected by comparing against limit-1 while the event is present.
  localparam int GOOD_W = (LOCK_CNT > 1) ? $clog2(LOCK_CNT) : 1;
  localparam int MISS_W = (LOSS_THRESH > 1) ? $clog2(LOSS_THRESH) : 1;

  localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_CNT - 1);
  localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(LOSS_THRESH - 1);

  typedef enum logic [1:0] {
    SEARCH = 2'b00,
    VERIFY = 2'b01,
    LOCKED = 2'b10,
    UNUSED = 2'b11
  } state_t;

  // --------------------------------------------------------------------------
  // Generator helpers
  // --------------------------------------------------------------------------

  // One step of the transmitter's generator.
  function automatic logic [3:0] gen_step(input logic [3:0] s);
    logic fb;
    fb = (~s[3] & ~s[2] & ~s[1]) ^ s[0];
    return {fb, s[3] ^ fb, s[2], s[1]};
  endfunction

  // Four steps: turns the state that produced a 4-bit window into the
  // state that will produce the bit following that window.
  function automatic logic [3:0] gen_step4(input logic [3:0] s);
    logic [3:0] t;
    t = s;
    for (int i = 0; i < 4; i++) begin
      t = gen_step(t);
    end
    return t;
  endfunction

  // Rebuild the generator state from a window w = {d3,d2,d1,d0}.
  // d0..d2 are S0..S2 directly. d3 is S3 ^ fb, where fb = S0 whenever S2 or
  // S1 is set, so S3 = d3 ^ d0 in that case. When S2 = S1 = 0 the window
  // cannot tell the two candidates apart; fb = 0 (S3 = d3) is taken and a
  // wrong guess is thrown out by VERIFY like any other bad phase.
  function automatic logic [3:0] recover(input logic [3:0] w);
    logic s3;
    s3 = w[3] ^ ((w[2] | w[1]) ? w[0] : 1'b0);
    return {s3, w[2:0]};
  endfunction

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t            fsm;
  logic [1:0]        fill_cnt;
  logic [2:0]        fill;       // {d2,d1,d0} once three bits are in
  logic [3:0]        gen;        // local generator, gen[0] is the expected bit
  logic [GOOD_W-1:0] good_cnt;
  logic [MISS_W-1:0] miss_cnt;

  // --------------------------------------------------------------------------
  // Combinational helpers
  // --------------------------------------------------------------------------
  logic             match;
  logic [3:0]       gen_next;
  logic [3:0]       gen_load;
  logic [CNT_W-1:0] err_cnt_inc;

  assign match       = (din == gen[0]);
  assign gen_next    = gen_step(gen);
  assign gen_load    = gen_step4(recover({din, fill}));
  assign err_cnt_inc = (&err_cnt) ? err_cnt : err_cnt + CNT_W'(1);

  assign state = fsm;

  // Fill shift register carries data only; fill_cnt decides when it is
  // complete, so it needs no reset.
  always_ff @(posedge clk) begin
    if (din_valid && (fsm == SEARCH)) begin
      fill <= {din, fill[2:1]};
    end
  end

  // --------------------------------------------------------------------------
  // Checker FSM with registered outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm      <= SEARCH;
      locked   <= 1'b0;
      err      <= 1'b0;
      err_cnt  <= '0;
      fill_cnt <= 2'd0;
      good_cnt <= '0;
      miss_cnt <= '0;
      gen      <= 4'b1111;
    end else begin
      // err is a single-cycle pulse; it ends on the next edge whether or
      // not that edge carries a valid bit.
      err <= 1'b0;

      if (clr_cnt) begin
        err_cnt <= '0;
      end

      case (fsm)
        SEARCH: begin
          if (din_valid) begin
            if (fill_cnt == 2'd3) begin
              gen      <= gen_load;
              fill_cnt <= 2'd0;
              good_cnt <= '0;
              miss_cnt <= '0;
              fsm      <= VERIFY;
            end else begin
              fill_cnt <= fill_cnt + 2'd1;
            end
          end
        end

        VERIFY: begin
          if (din_valid) begin
            gen <= gen_next;
            if (match) begin
              if (good_cnt == GOOD_LAST) begin
                fsm      <= LOCKED;
                locked   <= 1'b1;
                good_cnt <= '0;
                miss_cnt <= '0;
              end else begin
                good_cnt <= good_cnt + GOOD_W'(1);
              end
            end else begin
              // A bad phase guess is not an error; just search again.
              fsm      <= SEARCH;
              fill_cnt <= 2'd0;
              good_cnt <= '0;
              miss_cnt <= '0;
            end
          end
        end

        LOCKED: begin
          if (din_valid) begin
            gen <= gen_next;
            if (match) begin
              miss_cnt <= '0;
            end else begin
              err <= 1'b1;
              if (!clr_cnt) begin
                err_cnt <= err_cnt_inc;
              end
              if (miss_cnt == MISS_LAST) begin
                fsm      <= SEARCH;
                locked   <= 1'b0;
                fill_cnt <= 2'd0;
                good_cnt <= '0;
                miss_cnt <= '0;
              end else begin
                miss_cnt <= miss_cnt + MISS_W'(1);
              end
            end
          end
        end

        default: begin
          // Unused encoding: fall back to a clean SEARCH on the next edge.
          fsm      <= SEARCH;
          locked   <= 1'b0;
          fill_cnt <= 2'd0;
          good_cnt <= '0;
          miss_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cfsr4_checker.sv
// ============================================================================
// tb_cfsr4_checker
//
// Directed bench for cfsr4_checker with default parameters
// (LOCK_CNT=8, LOSS_THRESH=3, CNT_W=8). The reference stream
// 1110 0010 0011 0101 is indexed by a running position so that every bit
// sent, good or inverted, advances the transmitter phase by one.
// ============================================================================
module tb_cfsr4_checker;

  logic       clk       = 1'b0;
  logic       rst       = 1'b1;
  logic       din       = 1'b0;
  logic       din_valid = 1'b0;
  logic       clr_cnt   = 1'b0;
  logic       locked;
  logic       err;
  logic [7:0] err_cnt;
  logic [1:0] state;

  int          n_cmp    = 0;
  int          n_fail   = 0;
  int          pos      = 0;
  logic        err_seen = 1'b0;
  logic [0:15] str      = 16'b1110_0010_0011_0101;

  always #5 clk = ~clk;

  cfsr4_checker #(
    .LOCK_CNT   (8),
    .LOSS_THRESH(3),
    .CNT_W      (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .din      (din),
    .din_valid(din_valid),
    .clr_cnt  (clr_cnt),
    .locked   (locked),
    .err      (err),
    .err_cnt  (err_cnt),
    .state    (state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: inputs change on the falling edge, outputs are sampled 1ns
  // after the rising edge.
  task automatic drive(input logic b, input logic v, input logic c);
    @(negedge clk);
    din       = b;
    din_valid = v;
    clr_cnt   = c;
    @(posedge clk);
    #1;
    din_valid = 1'b0;
    clr_cnt   = 1'b0;
    err_seen  = err_seen | err;
  endtask

  task automatic good();
    drive(str[pos % 16], 1'b1, 1'b0);
    pos++;
  endtask

  task automatic bad(input logic c);
    drive(~str[pos % 16], 1'b1, c);
    pos++;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    // ---------------- reset, checked without any clock edge ----------------
    #1 rst = 1'b0;
    #2;
    check("rst_locked", 32'(locked), 0);
    check("rst_err", 32'(err), 0);
    check("rst_cnt", 32'(err_cnt), 0);
    check("rst_state", 32'(state), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // ---------------- clean lock from stream index 0 ----------------
    pos = 0;
    err_seen = 1'b0;
    repeat (3) good();
    check("a_fill3_state", 32'(state), 0);
    good();
    check("a_fill4_state", 32'(state), 1);
    repeat (7) good();
    check("a_11_state", 32'(state), 1);
    check("a_11_locked", 32'(locked), 0);
    good();
    check("a_12_locked", 32'(locked), 1);
    check("a_12_state", 32'(state), 2);
    repeat (4) good();
    check("a_hold_locked", 32'(locked), 1);
    check("a_cnt", 32'(err_cnt), 0);
    check("a_no_err", 32'(err_seen), 0);

    // ---------------- single errors while locked ----------------
    bad(1'b0);
    check("b_err1", 32'(err), 1);
    check("b_cnt1", 32'(err_cnt), 1);
    check("b_locked1", 32'(locked), 1);
    good();
    check("b_err_end", 32'(err), 0);
    check("b_locked2", 32'(locked), 1);
    // miss-run was cleared by the good bit, so two more do not lose lock
    bad(1'b0);
    bad(1'b0);
    check("b_two_locked", 32'(locked), 1);
    check("b_two_cnt", 32'(err_cnt), 3);
    good();
    bad(1'b0);
    check("b_err4", 32'(err), 1);
    idle();
    check("b_idle_err", 32'(err), 0);
    check("b_idle_cnt", 32'(err_cnt), 4);
    check("b_idle_state", 32'(state), 2);
    good();

    // ---------------- loss of lock and relock ----------------
    bad(1'b0);
    check("c_m1_locked", 32'(locked), 1);
    bad(1'b0);
    check("c_m2_locked", 32'(locked), 1);
    bad(1'b0);
    check("c_m3_err", 32'(err), 1);
    check("c_m3_cnt", 32'(err_cnt), 7);
    check("c_m3_locked", 32'(locked), 0);
    check("c_m3_state", 32'(state), 0);
    repeat (11) good();
    check("c_11_locked", 32'(locked), 0);
    good();
    check("c_12_locked", 32'(locked), 1);

    // ---------------- clear coinciding with a mismatch ----------------
    bad(1'b1);
    check("d_clr_cnt", 32'(err_cnt), 0);
    check("d_clr_err", 32'(err), 1);
    check("d_clr_locked", 32'(locked), 1);
    good();
    check("d_after_cnt", 32'(err_cnt), 0);

    // ---------------- saturation ----------------
    for (int k = 0; k < 260; k++) begin
      bad(1'b0);
      good();
      if (k == 199) check("e_cnt200", 32'(err_cnt), 200);
    end
    check("e_sat", 32'(err_cnt), 255);
    check("e_locked", 32'(locked), 1);
    bad(1'b0);
    check("e_sat_hold", 32'(err_cnt), 255);
    check("e_sat_err", 32'(err), 1);

    // ---------------- asynchronous reset mid-LOCKED ----------------
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("f_locked", 32'(locked), 0);
    check("f_err", 32'(err), 0);
    check("f_cnt", 32'(err_cnt), 0);
    check("f_state", 32'(state), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // ---------------- mismatch during VERIFY ----------------
    pos = 0;
    err_seen = 1'b0;
    repeat (5) good();
    check("g_verify_state", 32'(state), 1);
    bad(1'b0);
    check("g_back_state", 32'(state), 0);
    check("g_back_err", 32'(err), 0);
    check("g_back_cnt", 32'(err_cnt), 0);
    repeat (11) good();
    check("g_11_locked", 32'(locked), 0);
    good();
    check("g_12_locked", 32'(locked), 1);
    check("g_no_err", 32'(err_seen), 0);

    // ---------------- phase 5 with gaps ----------------
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    pos = 5;
    err_seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      repeat (k % 3) idle();
      good();
      if (k == 10) begin
        check("h_11_state", 32'(state), 1);
        check("h_11_locked", 32'(locked), 0);
      end
    end
    check("h_12_locked", 32'(locked), 1);
    idle();
    idle();
    check("h_gap_state", 32'(state), 2);
    check("h_cnt", 32'(err_cnt), 0);
    check("h_no_err", 32'(err_seen), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
